// File: rtl/sap1_pkg.sv
// sap1_pkg
// Shared definitions for the SAP-1 controller/sequencer:
//   - instruction opcodes (upper nibble of the instruction register)
//   - one-hot T-state encodings T1..T6
//   - bit positions of the 12-bit control word, ordered
//     Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo from MSB to LSB
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Ring counter states, one-hot: bit0 = T1 ... bit5 = T6
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter
// Six-state one-hot ring counter T1 -> T2 -> ... -> T6 -> T1.
// Ports:
//   CLK     in   rising-edge clock
//   CLR     in   synchronous active-high reset, forces T1 (highest priority)
//   hold    in   keep the current state (used while halted)
//   restart in   jump back to T1 on the next edge (early instruction end)
//   t_state out  6-bit one-hot state, bit0 = T1 ... bit5 = T6
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] t_state
);

    t_state_e state;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= T1;
        end else if (hold) begin
            state <= state;
        end else if (restart) begin
            state <= T1;
        end else begin
            case (state)
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= T4;
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= T1;
                // Any corrupted encoding recovers to a legal one-hot state
                default: state <= T1;
            endcase
        end
    end

    assign t_state = state;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer
// SAP-1 control unit: runs the T1..T6 ring counter and decodes the opcode
// into the datapath control lines. Controls are combinational from
// (t_state, opcode, halted); the only state is the ring and the halted flag.
// Ports:
//   CLK, CLR          clock and synchronous active-high reset
//   opcode[3:0]       instruction register upper nibble, used in T4..T6
//   t_state[5:0]      one-hot ring state (debug/observability)
//   Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo   active-high control lines
//   HALT              processor halted; only CLR leaves this condition
// Build option:
//   SAP1_VAR_CYCLE_EN  when defined, instructions end early once no further
//                      T-state has work (LDA after T5, OUT/NOP after T4).
module sap1_controller_sequencer
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       HALT
);

    logic            halted;
    logic            hold;
    logic            restart;
    logic            hlt_at_t4;
    logic [CW_W-1:0] ctrl;

    assign hlt_at_t4 = (t_state == T4) && (opcode == OP_HLT);

    // The edge ending T4 of HLT both sets halted and must not advance the
    // ring, so hold covers that edge as well as the halted period itself.
    assign hold = halted || hlt_at_t4;

`ifdef SAP1_VAR_CYCLE_EN
    logic known_t4_work;
    assign known_t4_work = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                           (opcode == OP_SUB) || (opcode == OP_HLT);
    assign restart = ((t_state == T5) && (opcode == OP_LDA)) ||
                     ((t_state == T4) && !known_t4_work)      ||
                     ((t_state == T4) && (opcode == OP_OUT));
`else
    assign restart = 1'b0;
`endif

    sap1_ring_counter u_ring (
        .CLK     (CLK),
        .CLR     (CLR),
        .hold    (hold),
        .restart (restart),
        .t_state (t_state)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halted <= 1'b0;
        end else if (hlt_at_t4) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        if (!halted) begin
            case (t_state)
                T1: begin
                    ctrl[CW_EP] = 1'b1;
                    ctrl[CW_LM] = 1'b1;
                end
                T2: ctrl[CW_CP] = 1'b1;
                T3: begin
                    ctrl[CW_CE] = 1'b1;
                    ctrl[CW_LI] = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl[CW_EI] = 1'b1;
                            ctrl[CW_LM] = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl[CW_EA] = 1'b1;
                            ctrl[CW_LO] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl[CW_CE] = 1'b1;
                            ctrl[CW_LA] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl[CW_CE] = 1'b1;
                            ctrl[CW_LB] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ctrl[CW_EU] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                        ctrl[CW_SU] = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Cp   = ctrl[CW_CP];
    assign Ep   = ctrl[CW_EP];
    assign Lm   = ctrl[CW_LM];
    assign CE   = ctrl[CW_CE];
    assign Li   = ctrl[CW_LI];
    assign Ei   = ctrl[CW_EI];
    assign La   = ctrl[CW_LA];
    assign Ea   = ctrl[CW_EA];
    assign Su   = ctrl[CW_SU];
    assign Eu   = ctrl[CW_EU];
    assign Lb   = ctrl[CW_LB];
    assign Lo   = ctrl[CW_LO];
    assign HALT = halted;

endmodule
